// File: rtl/alu_operand_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_operand_stack                                          |
// | Description : Hardware data stack feeding the 16-bit signed ALU. The top  |
// |               two entries are presented as ALU operands, and the ALU      |
// |               result is written back on BIN/UN. One command is executed   |
// |               per accepted valid/ready handshake.                         |
// | Ports       : clk_i         system clock, rising edge                     |
// |               rst_ni        synchronous active-low reset                  |
// |               cmd_valid_i   command request                               |
// |               cmd_ready_o   command can be accepted this cycle            |
// |               cmd_i         0 NOP 1 PUSH 2 POP 3 BIN 4 UN 5 DUP 6 SWAP    |
// |                             7 CLR                                         |
// |               din_i         immediate for PUSH                            |
// |               alu_a_o/b_o   ALU operands                                  |
// |               alu_s_i       ALU result (combinational from a/b/f)         |
// |               top_o         top entry, 0 when empty                       |
// |               count_o       number of valid entries                       |
// |               empty_o/full_o occupancy flags                              |
// |               err_o         sticky error flag                             |
// |               err_code_o    first error: 1 underflow, 2 overflow          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module alu_operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_i,
  input  logic signed [WIDTH-1:0] din_i,
  output logic signed [WIDTH-1:0] alu_a_o,
  output logic signed [WIDTH-1:0] alu_b_o,
  input  logic signed [WIDTH-1:0] alu_s_i,
  output logic signed [WIDTH-1:0] top_o,
  output logic [CW-1:0]           count_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] c_cmd_nop  = 3'd0;
  localparam logic [2:0] c_cmd_push = 3'd1;
  localparam logic [2:0] c_cmd_pop  = 3'd2;
  localparam logic [2:0] c_cmd_bin  = 3'd3;
  localparam logic [2:0] c_cmd_un   = 3'd4;
  localparam logic [2:0] c_cmd_dup  = 3'd5;
  localparam logic [2:0] c_cmd_swap = 3'd6;
  localparam logic [2:0] c_cmd_clr  = 3'd7;

  localparam logic [1:0] c_err_none = 2'd0;
  localparam logic [1:0] c_err_udf  = 2'd1;
  localparam logic [1:0] c_err_ovf  = 2'd2;

  // Entry 0 is the bottom of the stack; the top lives at index count-1.
  logic signed [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          ready_q, ready_d;

  logic [AW-1:0] idx_t;     // top
  logic [AW-1:0] idx_n;     // second
  logic [AW-1:0] idx_push;  // first free slot
  logic          has_t, has_n, is_full;
  logic signed [WIDTH-1:0] t_val, n_val;

  logic          accept;
  logic          wr_ok;
  logic [1:0]    fault;

  assign idx_t    = AW'(count_q - CW'(1));
  assign idx_n    = AW'(count_q - CW'(2));
  assign idx_push = AW'(count_q);

  assign has_t   = (count_q != '0);
  assign has_n   = (count_q >= CW'(2));
  assign is_full = (count_q == CW'(DEPTH));

  // Missing entries read as zero so stale array contents never leak out.
  assign t_val = has_t ? mem_q[idx_t] : '0;
  assign n_val = has_n ? mem_q[idx_n] : '0;

  // Operand mux follows cmd_i even when no command is being requested,
  // so the ALU result is already settled by the accepting edge.
  assign alu_a_o = (cmd_i == c_cmd_un) ? t_val : n_val;
  assign alu_b_o = (cmd_i == c_cmd_un) ? '0    : t_val;

  assign top_o       = t_val;
  assign count_o     = count_q;
  assign empty_o     = ~has_t;
  assign full_o      = is_full;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign cmd_ready_o = ready_q;

  assign accept = cmd_valid_i & ready_q;

  always_comb begin
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ready_d    = 1'b1;
    wr_ok      = 1'b0;
    fault      = c_err_none;

    if (accept) begin
      case (cmd_i)
        c_cmd_nop: ;
        c_cmd_push: begin
          if (is_full) fault = c_err_ovf;
          else begin
            wr_ok   = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        c_cmd_pop: begin
          if (!has_t) fault = c_err_udf;
          else count_d = count_q - CW'(1);
        end
        c_cmd_bin: begin
          if (!has_n) fault = c_err_udf;
          else begin
            wr_ok   = 1'b1;
            count_d = count_q - CW'(1);
          end
        end
        c_cmd_un: begin
          if (!has_t) fault = c_err_udf;
          else wr_ok = 1'b1;
        end
        c_cmd_dup: begin
          // Empty takes precedence: with nothing to copy it is an underflow.
          if (!has_t)       fault = c_err_udf;
          else if (is_full) fault = c_err_ovf;
          else begin
            wr_ok   = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        c_cmd_swap: begin
          if (!has_n) fault = c_err_udf;
          else wr_ok = 1'b1;
        end
        c_cmd_clr: begin
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = c_err_none;
          ready_d    = 1'b0;   // one dead cycle while the array is wiped
        end
        default: ;
      endcase

      if (fault != c_err_none) begin
        err_d = 1'b1;
        if (!err_q) err_code_d = fault;   // first error is kept
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= c_err_none;
      ready_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      ready_q    <= ready_d;
    end
  end

  // Array has no reset; it is wiped during any not-ready cycle and otherwise
  // only written by legal commands. Reset blocks a coincident write.
  always_ff @(posedge clk_i) begin
    if (!ready_q) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (rst_ni && wr_ok) begin
      case (cmd_i)
        c_cmd_push: mem_q[idx_push] <= din_i;
        c_cmd_bin:  mem_q[idx_n]    <= alu_s_i;
        c_cmd_un:   mem_q[idx_t]    <= alu_s_i;
        c_cmd_dup:  mem_q[idx_push] <= t_val;
        c_cmd_swap: begin
          mem_q[idx_t] <= n_val;
          mem_q[idx_n] <= t_val;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
